iir_output_decimator: RTL
=========================

// Module: iir_output_decimator
// PURPOSE
// - Downstream stage of the Chebyshev-I IIR lowpass filter. Takes its 64-bit fixed-point output (Q11.52) every clock.
// - Keeps every DECIM-th sample, rounds and saturates it to a narrow signed word, and buffers it in a small FIFO.
// - Hands samples to the consumer over a valid/ready interface.
// PARAMETERS
// - IN_W      64  input sample width, two's complement
// - IN_FRAC   52  input fractional bits
// - OUT_W     16  output sample width, two's complement
// - OUT_FRAC  15  output fractional bits; IN_FRAC-OUT_FRAC must be >= 1
// - DECIM_W    8  width of decimation factor port
// - FIFO_AW    3  FIFO address width; depth = 2**FIFO_AW
// PORTS
// - clock       in   1          single clock, rising edge
// - reset       in   1          asynchronous, active-low (0 = in reset)
// - Data_in     in   IN_W       filtered sample from IIR stage
// - in_valid    in   1          Data_in valid this cycle
// - decim       in   DECIM_W    decimation factor M; 0 and 1 both mean keep all
// - Data_out    out  OUT_W      head-of-FIFO sample
// - out_valid   out  1          FIFO not empty
// - out_ready   in   1          consumer accepts Data_out when out_valid&&out_ready
// - fifo_level  out  FIFO_AW+1  current FIFO occupancy
// - overflow    out  1          sticky: a kept sample was dropped because the FIFO was full
// - clear_ovf   in   1          clears overflow (and sat_count)
// - sat_count   out  16         saturated-sample count (see CONFIGURATION)
// BEHAVIOUR
// - Reset (async, reset==0): phase counter=0, stage reg empty, FIFO empty.
//   Outputs: out_valid=0, Data_out=0, fifo_level=0, overflow=0, sat_count=0.
//   Reset mid-operation discards all buffered samples.
// - Phase counter cnt: on in_valid with cnt==0, the sample is kept and cnt<=M-1 (0 if M<=1).
//   On in_valid with cnt!=0, the sample is dropped and cnt<=cnt-1. With in_valid=0, cnt holds.
//   First valid sample after reset is always kept. A change on decim takes effect at the next reload only.
// - Requantize (S=IN_FRAC-OUT_FRAC): r = (Data_in + 2**(S-1)) >>> S in full IN_W+1 width (no wrap).
//   Rounding is round-half-up.
//   Saturation: r > 2**(OUT_W-1)-1 -> 0x7FFF; r < -2**(OUT_W-1) -> 0x8000 (values given for OUT_W=16).
// - Pipeline: the kept sample is requantized and registered at edge n (stage reg).
//   It is written to the FIFO at edge n+1. If the FIFO was empty, out_valid=1 and Data_out is valid in cycle n+2.
//   Latency = 2 clocks.
// - FIFO is show-ahead: Data_out = mem[rd_ptr] when out_valid, else 0. A pop occurs on out_valid&&out_ready.
// - Write is allowed when level<depth, or when level==depth and a pop occurs in the same cycle.
//   On a simultaneous push and pop, level is unchanged. Pointers wrap modulo depth.
//   fifo_level ranges from 0 to depth.
// - Full drop: if a write is blocked, the sample is discarded and overflow<=1. FIFO contents are unchanged.
// - clear_ovf: overflow<=0. If a drop occurs in the same cycle, set wins (overflow stays 1).
// - out_ready is ignored when out_valid=0. Popping an empty FIFO is impossible.
// CONFIGURATION
// - Macro IIR_OUT_SATCNT_EN.
//   - Defined: sat_count increments on each kept sample that saturated and sticks at 0xFFFF.
//     clear_ovf zeroes it; an increment in the same cycle as clear_ovf gives sat_count=1.
//   - Not defined: no counter logic; sat_count is tied to 0. All other behaviour is identical.
// TESTING (defaults OUT_W=16, OUT_FRAC=15, depth 8; out_ready=1 unless stated)
// - T1 latency: decim=1, Data_in=1<<51 (0.5) at cycle 0
//   -> Data_out=0x4000, out_valid=1 in cycle 2, fifo_level returns to 0 after pop.
// - T2 decimation: decim=4, Data_in=k<<37 for k=0..15 back-to-back
//   -> outputs 0,4,8,12 in order; decim=0 -> all 16 samples out.
// - T3 saturation/rounding: 1<<53 -> 0x7FFF; -(1<<53) -> 0x8000; 1<<36 -> 0x0001; (1<<36)-1 -> 0x0000; -(1<<36) -> 0x0000.
//   With macro: sat_count=2; without macro: sat_count=0.
// - T4 full/overflow: decim=1, out_ready=0, 10 samples (k<<37, k=1..10)
//   -> fifo_level=8, overflow=1; then out_ready=1 -> reads 1..8 in order.
//   Also: clear_ovf and a drop in the same cycle -> overflow=1.
// - T5 simultaneous push/pop at full: level=8, out_ready=1, new sample arriving
//   -> level stays 8, new sample stored, overflow stays 0.
// - T6 async reset: assert reset=0 mid-stream between clock edges
//   -> out_valid=0, Data_out=0, fifo_level=0, overflow=0 immediately; first sample after release is kept.

Source files
------------

// File: rtl/iir_output_decimator.sv
// rtl/iir_output_decimator.sv - decimate, round/saturate and FIFO-buffer IIR filter output samples
// Optional saturated-sample counter enabled by defining IIR_OUT_SATCNT_EN.
module iir_output_decimator #(
    parameter int IN_W     = 64,
    parameter int IN_FRAC  = 52,
    parameter int OUT_W    = 16,
    parameter int OUT_FRAC = 15,
    parameter int DECIM_W  = 8,
    parameter int FIFO_AW  = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [IN_W-1:0]    Data_in,
    input  logic               in_valid,
    input  logic [DECIM_W-1:0] decim,
    output logic [OUT_W-1:0]   Data_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               overflow,
    input  logic               clear_ovf,
    output logic [15:0]        sat_count
);

    localparam int S     = IN_FRAC - OUT_FRAC;
    localparam int EXT_W = IN_W + 1;
    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [EXT_W-1:0]   HALF       = {{(EXT_W-1){1'b0}}, 1'b1} << (S - 1);
    localparam logic [FIFO_AW:0]   LEVEL_FULL = (FIFO_AW+1)'(DEPTH);
    localparam logic [OUT_W-1:0]   OUT_MAX    = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]   OUT_MIN    = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [DECIM_W-1:0] DECIM_ONE  = DECIM_W'(1);

    logic [DECIM_W-1:0] cnt;
    logic               keep;

    assign keep = in_valid && (cnt == '0);

    // A new decimation factor is only sampled when the counter reloads.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (in_valid) begin
            if (cnt == '0) begin
                cnt <= (decim > DECIM_ONE) ? (decim - DECIM_ONE) : '0;
            end else begin
                cnt <= cnt - DECIM_ONE;
            end
        end
    end

    logic signed [EXT_W-1:0] ext_in;
    logic signed [EXT_W-1:0] rounded;
    logic signed [EXT_W-1:0] shifted;
    logic                    pos_sat;
    logic                    neg_sat;
    logic [OUT_W-1:0]        quant;

    // One guard bit keeps the half-LSB add from wrapping near full scale.
    assign ext_in  = {Data_in[IN_W-1], Data_in};
    assign rounded = ext_in + $signed(HALF);
    assign shifted = rounded >>> S;

    assign pos_sat = !shifted[EXT_W-1] && (|shifted[EXT_W-2:OUT_W-1]);
    assign neg_sat =  shifted[EXT_W-1] && !(&shifted[EXT_W-2:OUT_W-1]);

    always_comb begin
        quant = shifted[OUT_W-1:0];
        if (pos_sat) begin
            quant = OUT_MAX;
        end else if (neg_sat) begin
            quant = OUT_MIN;
        end
    end

    logic             stg_valid;
    logic [OUT_W-1:0] stg_data;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stg_valid <= 1'b0;
            stg_data  <= '0;
        end else begin
            stg_valid <= keep;
            if (keep) begin
                stg_data <= quant;
            end
        end
    end

    logic [OUT_W-1:0]   mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   level;
    logic               pop;
    logic               can_write;
    logic               push;
    logic               drop;

    assign pop       = (level != '0) && out_ready;
    assign can_write = (level != LEVEL_FULL) || pop;
    assign push      = stg_valid && can_write;
    assign drop      = stg_valid && !can_write;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= stg_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_ovf) begin
            overflow <= 1'b0;
        end
    end

`ifdef IIR_OUT_SATCNT_EN
    logic sat_inc;

    assign sat_inc = keep && (pos_sat || neg_sat);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sat_count <= '0;
        end else if (clear_ovf) begin
            sat_count <= sat_inc ? 16'd1 : 16'd0;
        end else if (sat_inc && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end
`else
    assign sat_count = '0;
`endif

    assign out_valid  = (level != '0);
    assign Data_out   = out_valid ? mem[rd_ptr] : '0;
    assign fifo_level = level;

endmodule
